// File: rtl/pe_array_drain.sv
// pe_array_drain: snapshots PE result planes into ping-pong banks and streams them out one element per beat
module pe_array_drain #(
    parameter int ROWS   = 16,
    parameter int COLS   = 2,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [COLS-1:0][ROWS-1:0][DATA_W-1:0]   pe_array_out,
    input  logic                                    rounder_valid,
    input  logic [TAG_W-1:0]                        round_number,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [DATA_W-1:0]                       out_data,
    output logic [$clog2(COLS*ROWS)-1:0]            out_idx,
    output logic [TAG_W-1:0]                        out_tag,
    output logic                                    out_last,
    output logic                                    busy,
    output logic                                    overflow
);
    localparam int BEATS = COLS * ROWS;
    localparam int IDX_W = $clog2(BEATS);

    logic [BEATS*DATA_W-1:0] plane [2];
    logic [TAG_W-1:0]        tag   [2];
    logic [1:0]              full;
    logic                    wr_ptr, rd_ptr;
    logic [IDX_W-1:0]        cnt;
    logic                    fire, last_hs, cap;

    assign out_valid = full[rd_ptr];
    assign fire      = out_valid && out_ready;
    assign last_hs   = fire && cnt == IDX_W'(BEATS - 1);
    // a bank emptied by this cycle's last beat is reusable by a coincident capture
    assign cap       = rounder_valid && (!full[wr_ptr] || (last_hs && rd_ptr == wr_ptr));
    // beat index {col,row} is exactly the element's position in the packed plane
    assign out_data  = out_valid ? plane[rd_ptr][cnt*DATA_W +: DATA_W] : '0;
    assign out_idx   = cnt;
    assign out_tag   = out_valid ? tag[rd_ptr] : '0;
    assign out_last  = out_valid && cnt == IDX_W'(BEATS - 1);
    assign busy      = |full;

    // store an accepted plane and its tag into the write bank
    always_ff @(posedge clk) begin
        if (cap) begin
            plane[wr_ptr] <= pe_array_out;
            tag[wr_ptr]   <= round_number;
        end
    end

    // bank occupancy, pointers, beat counter and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (fire) cnt <= last_hs ? '0 : cnt + 1'b1;
            if (last_hs) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
            if (cap) begin
                full[wr_ptr] <= 1'b1;
                wr_ptr       <= ~wr_ptr;
            end
            if (rounder_valid && !cap) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pe_array_drain.sv
// tb_pe_array_drain: directed tests of the result drain against a plane-queue model
module tb_pe_array_drain;
    typedef logic [1:0][15:0][15:0] plane_t;
    typedef struct packed {logic [3:0] tag; plane_t p;} mplane_t;
    typedef struct packed {logic [3:0] tag; logic [4:0] idx; logic [15:0] d;} beat_t;

    logic        clk = 0;
    logic        rst_n = 1;
    plane_t      pe_array_out = '0;
    logic        rounder_valid = 0;
    logic [3:0]  round_number = '0;
    logic        out_valid, out_ready = 0;
    logic [15:0] out_data;
    logic [4:0]  out_idx;
    logic [3:0]  out_tag;
    logic        out_last, busy, overflow;

    int ncmp = 0, nbad = 0;
    mplane_t mq[$];
    int mk = 0;
    logic movf = 0;
    beat_t lg[$];

    pe_array_drain dut (
        .clk(clk), .rst_n(rst_n), .pe_array_out(pe_array_out),
        .rounder_valid(rounder_valid), .round_number(round_number),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_tag(out_tag), .out_last(out_last),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic plane_t mk_plane(input logic [15:0] off);
        plane_t p;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 16; r++)
                p[c][r] = 16'(16'h0100 * c + r) + off;
        return p;
    endfunction

    // model: FIFO of at most two planes; the head drains one element per accepted beat
    always @(negedge rst_n) begin
        mq.delete();
        mk = 0;
        movf = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (mq.size() > 0 && out_ready) begin
                if (mk == 31) begin
                    void'(mq.pop_front());
                    mk = 0;
                end else mk++;
            end
            if (rounder_valid) begin
                if (mq.size() < 2) mq.push_back('{tag: round_number, p: pe_array_out});
                else movf = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic mv;
        mv = mq.size() > 0;
        chk("out_valid", out_valid, mv);
        chk("busy", busy, mv);
        chk("overflow", overflow, movf);
        if (mv) begin
            chk("out_data", out_data, mq[0].p[mk / 16][mk % 16]);
            chk("out_idx", out_idx, mk);
            chk("out_tag", out_tag, mq[0].tag);
            chk("out_last", out_last, mk == 31);
        end
        if (rst_n && out_valid && out_ready) lg.push_back('{tag: out_tag, idx: out_idx, d: out_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [3:0] t, input logic [15:0] off);
        pe_array_out = mk_plane(off);
        round_number = t;
        rounder_valid = 1;
        tick();
        rounder_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        ticks(2);
        rst_n = 1;
        tick();
    endtask

    initial begin
        int bad;
        int n3;
        #1 rst_n = 0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_tag", out_tag, 0);
        ticks(2);
        rst_n = 1;
        tick();

        // single plane, ready high
        out_ready = 1;
        lg.delete();
        pulse(4'd7, 16'h0);
        chk("t1_valid_n1", out_valid, 1);
        chk("t1_first_data", out_data, 16'h0000);
        ticks(32);
        chk("t1_count", lg.size(), 32);
        chk("t1_d15", lg[15].d, 16'h000F);
        chk("t1_d16", lg[16].d, 16'h0100);
        chk("t1_d31", lg[31].d, 16'h010F);
        chk("t1_tag31", lg[31].tag, 7);
        chk("t1_idle", out_valid, 0);

        // backpressure: ready alternates
        lg.delete();
        pulse(4'd7, 16'h0);
        for (int i = 0; i < 64; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        out_ready = 1;
        chk("bp_count", lg.size(), 32);
        bad = 0;
        for (int k = 0; k < lg.size(); k++)
            if (lg[k].idx != k || lg[k].d != (k < 16 ? k : 16'h0100 + k - 16)) bad++;
        chk("bp_order", bad, 0);

        // ping-pong, no bubble
        lg.delete();
        pulse(4'd1, 16'h0);
        ticks(2);
        pulse(4'd2, 16'h1000);
        ticks(61);
        chk("pp_count", lg.size(), 64);
        chk("pp_tag31", lg[31].tag, 1);
        chk("pp_tag32", lg[32].tag, 2);
        chk("pp_d32", lg[32].d, 16'h1000);
        chk("pp_d63", lg[63].d, 16'h110F);
        chk("pp_ovf", overflow, 0);

        // capture coinciding with last-beat free while both banks full
        lg.delete();
        pulse(4'd1, 16'h0);
        pulse(4'd2, 16'h2000);
        ticks(30);
        pulse(4'd5, 16'h5000);
        ticks(70);
        chk("sim_count", lg.size(), 96);
        chk("sim_tag0", lg[0].tag, 1);
        chk("sim_tag32", lg[32].tag, 2);
        chk("sim_tag64", lg[64].tag, 5);
        chk("sim_d64", lg[64].d, 16'h5000);
        chk("sim_ovf", overflow, 0);

        // overflow with ready low
        do_reset();
        lg.delete();
        out_ready = 0;
        pulse(4'd1, 16'h0);
        pulse(4'd2, 16'h0);
        pulse(4'd3, 16'h0);
        chk("ov_flag", overflow, 1);
        out_ready = 1;
        ticks(70);
        chk("ov_count", lg.size(), 64);
        chk("ov_tag0", lg[0].tag, 1);
        chk("ov_tag63", lg[63].tag, 2);
        n3 = 0;
        foreach (lg[k]) if (lg[k].tag == 3) n3++;
        chk("ov_no_tag3", n3, 0);
        chk("ov_sticky", overflow, 1);

        // reset mid-stream
        lg.delete();
        pulse(4'd9, 16'h0);
        ticks(10);
        chk("mr_idx10", out_idx, 10);
        #2 rst_n = 0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ovf", overflow, 0);
        ticks(2);
        rst_n = 1;
        tick();
        lg.delete();
        pulse(4'd4, 16'h0);
        chk("mr_restart_idx", out_idx, 0);
        ticks(32);
        chk("mr_count", lg.size(), 32);
        chk("mr_first_idx", lg[0].idx, 0);
        chk("mr_first_tag", lg[0].tag, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule

// File: doc/pe_array_drain.md
# pe_array_drain

Result drain for the PE array. Snapshots the full result plane (2 columns × 16 rows of 16-bit values) whenever the array flags `rounder_valid`, buffers up to two planes in ping-pong banks, and streams them out one element per beat on a valid/ready interface toward the writeback path. It sits directly downstream of `pe_array`, consuming `pe_array_out`, `rounder_valid` and `round_number`.

## Interface
- `ROWS`, 16: result rows per column (one per input-matrix element)
- `COLS`, 2: result columns (one per weight lane)
- `DATA_W`, 16: result element width
- `TAG_W`, 4: round-number width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `pe_array_out` in COLS×ROWS×DATA_W: packed result plane `[COLS-1:0][ROWS-1:0][DATA_W-1:0]`
- `rounder_valid` in 1: one-cycle pulse; plane valid this cycle
- `round_number` in TAG_W: round tag accompanying `rounder_valid`
- `out_valid` out 1: beat valid
- `out_ready` in 1: downstream accepts beat
- `out_data` out DATA_W: result element
- `out_idx` out $clog2(COLS*ROWS): beat index `{col,row}`
- `out_tag` out TAG_W: captured `round_number` of the plane
- `out_last` out 1: final beat of plane (idx = COLS*ROWS-1)
- `busy` out 1: at least one bank occupied
- `overflow` out 1: sticky; a plane was dropped

## Operation
- Two banks, each holding one plane plus its tag and a full flag. Write pointer and read pointer are 1 bit each; planes drain in arrival (FIFO) order.
- Capture: on a rising edge with `rounder_valid`=1, if the bank at the write pointer is free, store `pe_array_out` and `round_number` there, set full, and toggle the write pointer.
- If both banks are full at capture, drop the plane, set `overflow`, and leave the bank state untouched.
- A bank freed by a last-beat handshake in the same cycle counts as free for a capture in that cycle, so no drop occurs.
- Drain: the read bank streams beats k = 0..COLS*ROWS-1 with `out_data` = plane[k[MSB]][k[LSB+3:0]], i.e. column 0 rows 0..15, then column 1 rows 0..15.
  - The beat counter advances on `out_valid && out_ready`.
  - On the handshake of beat 31: clear full, toggle the read pointer, reset the counter to 0.
- `out_valid` = read bank full. While `out_valid && !out_ready`, `out_data`/`out_idx`/`out_tag`/`out_last` hold stable.
- Back-to-back planes: beat 0 of the next bank follows the last beat of the previous one with no bubble when that bank is already full.
- `busy` = either full flag set. `overflow` clears only on reset.
- Reset mid-stream: all full flags, pointers, counter and `overflow` clear immediately (asynchronously); any partial plane is discarded.

## Timing
- Reset values:
  - `out_valid`=0, `out_last`=0, `busy`=0, `overflow`=0
  - `out_data`=0, `out_idx`=0, `out_tag`=0
- Capture latency: `rounder_valid` sampled at edge N → `out_valid`=1 after edge N (usable at edge N+1) when the drain was idle.
- Throughput: 1 beat/cycle with `out_ready` held high; one plane drains in 32 cycles.
- Outputs are driven from registers/bank storage only; there is no combinational path from `out_ready` to `out_valid`.
- `overflow` rises the cycle after the dropping edge.

## Test plan
- Single plane, `out_ready`=1: plane[c][r] = 16'h0100*c + r, tag 4'd7, pulse at edge N.
  - Required: 32 beats, cycles N+1..N+32.
  - `out_data` = 0000..000F then 0100..010F; `out_tag`=7 on every beat; `out_last` only on idx 31.
- Backpressure: same plane, `out_ready` toggling 1,0,1,0.
  - Required: each beat is held through ready-low cycles with no loss or duplication; 32 accepted beats in 64 cycles.
- Ping-pong: plane A (tag 1) at N, plane B (tag 2, data +16'h1000) at N+3, `out_ready`=1.
  - Required: all of A, then all of B with no bubble; `overflow`=0.
- Overflow: `out_ready`=0, three pulses with tags 1, 2, 3.
  - Required: `overflow`=1 after the third pulse.
  - Releasing ready yields tag 1 then tag 2 only; tag 3 never appears.
- Simultaneous free/capture: both banks full; a new pulse (tag 5) coincides with the last-beat handshake of the draining bank.
  - Required: tag 5 is accepted and drained later; `overflow` stays 0.
- Reset mid-stream: assert `rst_n`=0 at beat 10 of a plane.
  - Required: `out_valid`, `busy` and `overflow` are 0 immediately.
  - After release, a new pulse drains starting from idx 0.
